// File: rtl/shared_mem_arb.sv
// Round-robin arbiter that owns a 32x8 unified memory shared by instruction fetch,
// LD/ST data access and a host loader port; the host can hold a bounded burst lock.
module shared_mem_arb #(
  parameter int DW       = 8,
  parameter int AW       = 5,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic          we0,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic          host_lock,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] rdata,
  output logic          locked
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  localparam logic [7:0] LAST_CNT   = 8'(LOCK_MAX - 1);
  localparam logic       CAN_LOCK   = (LOCK_MAX > 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    rvalid_q, rvalid_d;
  logic [1:0]    last_q, last_d;
  logic [0:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [2:0]    req;
  logic [2:0]    gnt;
  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req = {req2, req1, req0};

  // A held lock overrides rotation; otherwise search starting just after the last winner.
  always_comb begin
    gnt = 3'b000;
    if (state_q == LOCKED && req2) begin
      gnt = 3'b100;
    end else begin
      case (last_q)
        2'd0: begin
          if      (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        2'd1: begin
          if      (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if      (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  assign any_gnt = |gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[0]) begin
      sel_we = we0; sel_addr = addr0; sel_wdata = wdata0;
    end else if (gnt[1]) begin
      sel_we = we1; sel_addr = addr1; sel_wdata = wdata1;
    end else if (gnt[2]) begin
      sel_we = we2; sel_addr = addr2; sel_wdata = wdata2;
    end
  end

  always_comb begin
    last_d = last_q;
    if      (gnt[0]) last_d = 2'd0;
    else if (gnt[1]) last_d = 2'd1;
    else if (gnt[2]) last_d = 2'd2;

    rvalid_d = gnt & {3{~sel_we}};
    rdata_d  = (any_gnt && !sel_we) ? mem_q[sel_addr] : rdata_q;
  end

  // cnt counts host grants in the current burst, including the one that took the lock,
  // so a burst is exactly LOCK_MAX grants long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (gnt[2] && host_lock && CAN_LOCK) begin
          state_d = LOCKED;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        if (!req2 || !host_lock || cnt_q >= LAST_CNT) begin
          state_d = UNLOCKED;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (any_gnt && sel_we) begin
      mem_q[sel_addr] <= sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 3'b000;
      last_q   <= 2'd2;
      state_q  <= UNLOCKED;
      cnt_q    <= 8'd0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      last_q   <= last_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign gnt2    = gnt[2];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rvalid2 = rvalid_q[2];
  assign rdata   = rdata_q;
  assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_shared_mem_arb.sv
// Directed bench for shared_mem_arb: a vector table for single-cycle behaviour plus
// hand-written sequences for fairness, host lock bursts and mid-burst reset.
module tb_shared_mem_arb;

  logic       clk;
  logic       reset;
  logic       req0, req1, req2;
  logic       we0, we1, we2;
  logic [4:0] addr0, addr1, addr2;
  logic [7:0] wdata0, wdata1, wdata2;
  logic       host_lock;
  logic       gnt0, gnt1, gnt2;
  logic       rvalid0, rvalid1, rvalid2;
  logic [7:0] rdata;
  logic       locked;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic [2:0] req;
    logic [2:0] we;
    logic [4:0] a0, a1, a2;
    logic [7:0] d0, d1, d2;
    logic       hl;
    logic [2:0] expGnt;
    logic [2:0] expRvalid;
    logic [7:0] expRdata;
    logic       expLocked;
  } vec_t;

  vec_t vecs [16];

  shared_mem_arb #(.DW(8), .AW(5), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2),
    .we0(we0), .we1(we1), .we2(we2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .host_lock(host_lock),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic [2:0] req, logic [2:0] we,
                                 logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                 logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic hl,
                                 logic [2:0] eg, logic [2:0] ev, logic [7:0] ed, logic el);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.hl = hl;
    v.expGnt = eg; v.expRvalid = ev; v.expRdata = ed; v.expLocked = el;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    req0 = 0; req1 = 0; req2 = 0;
    we0 = 0; we1 = 0; we2 = 0;
    addr0 = 0; addr1 = 0; addr2 = 0;
    wdata0 = 0; wdata1 = 0; wdata2 = 0;
    host_lock = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one table row at the falling edge, checks the combinational grant,
  // then checks the registered outputs just after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    {req2, req1, req0} = v.req;
    {we2, we1, we0}    = v.we;
    addr0 = v.a0; addr1 = v.a1; addr2 = v.a2;
    wdata0 = v.d0; wdata1 = v.d1; wdata2 = v.d2;
    host_lock = v.hl;
    #1;
    checkOutput($sformatf("vec%0d gnt", idx), {5'b0, gnt2, gnt1, gnt0}, {5'b0, v.expGnt});
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d rvalid", idx), {5'b0, rvalid2, rvalid1, rvalid0}, {5'b0, v.expRvalid});
    checkOutput($sformatf("vec%0d rdata", idx), rdata, v.expRdata);
    checkOutput($sformatf("vec%0d locked", idx), {7'b0, locked}, {7'b0, v.expLocked});
  endtask

  initial begin
    logic [2:0] fairGnt [6];
    logic [2:0] lockGnt [13];
    logic       lockExp [13];

    nCompared   = 0;
    nMismatched = 0;
    reset = 1'b1;
    clearInputs();

    // Reset state and full readback of cleared memory through the host port.
    doReset();
    #1;
    checkOutput("reset rdata", rdata, 8'h00);
    checkOutput("reset rvalid", {5'b0, rvalid2, rvalid1, rvalid0}, 8'h00);
    checkOutput("reset locked", {7'b0, locked}, 8'h00);
    checkOutput("reset idle gnt", {5'b0, gnt2, gnt1, gnt0}, 8'h00);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      req2 = 1; we2 = 0; addr2 = 5'(a);
      #1;
      checkOutput($sformatf("clr%0d gnt2", a), {7'b0, gnt2}, 8'h01);
      @(posedge clk);
      #1;
      checkOutput($sformatf("clr%0d rvalid2", a), {7'b0, rvalid2}, 8'h01);
      checkOutput($sformatf("clr%0d rdata", a), rdata, 8'h00);
      checkOutput($sformatf("clr%0d locked", a), {7'b0, locked}, 8'h00);
    end

    //                 req     we      a0     a1     a2     d0     d1     d2     hl  gnt     rvalid  rdata  locked
    vecs[0]  = mkVec(3'b100, 3'b000, 5'h00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b100, 3'b100, 8'h00, 0);
    vecs[1]  = mkVec(3'b100, 3'b100, 5'h00, 5'h00, 5'h13, 8'h00, 8'h00, 8'hA5, 0, 3'b100, 3'b000, 8'h00, 0);
    vecs[2]  = mkVec(3'b001, 3'b000, 5'h13, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b001, 3'b001, 8'hA5, 0);
    vecs[3]  = mkVec(3'b010, 3'b010, 5'h00, 5'h05, 5'h00, 8'h00, 8'h3C, 8'h00, 0, 3'b010, 3'b000, 8'hA5, 0);
    vecs[4]  = mkVec(3'b010, 3'b000, 5'h00, 5'h05, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b010, 3'b010, 8'h3C, 0);
    vecs[5]  = mkVec(3'b000, 3'b000, 5'h00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b000, 3'b000, 8'h3C, 0);
    vecs[6]  = mkVec(3'b000, 3'b000, 5'h00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b000, 3'b000, 8'h3C, 0);
    vecs[7]  = mkVec(3'b011, 3'b000, 5'h13, 5'h05, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b001, 3'b001, 8'hA5, 0);
    vecs[8]  = mkVec(3'b010, 3'b000, 5'h00, 5'h05, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b010, 3'b010, 8'h3C, 0);
    vecs[9]  = mkVec(3'b101, 3'b001, 5'h1F, 5'h00, 5'h1F, 8'hFF, 8'h00, 8'h00, 0, 3'b100, 3'b100, 8'h00, 0);
    vecs[10] = mkVec(3'b101, 3'b001, 5'h1F, 5'h00, 5'h1F, 8'hFF, 8'h00, 8'h00, 0, 3'b001, 3'b000, 8'h00, 0);
    vecs[11] = mkVec(3'b100, 3'b000, 5'h00, 5'h00, 5'h1F, 8'h00, 8'h00, 8'h00, 0, 3'b100, 3'b100, 8'hFF, 0);
    vecs[12] = mkVec(3'b100, 3'b000, 5'h00, 5'h00, 5'h13, 8'h00, 8'h00, 8'h00, 1, 3'b100, 3'b100, 8'hA5, 1);
    vecs[13] = mkVec(3'b101, 3'b000, 5'h05, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1, 3'b100, 3'b100, 8'h00, 1);
    vecs[14] = mkVec(3'b101, 3'b000, 5'h05, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b100, 3'b100, 8'h00, 0);
    vecs[15] = mkVec(3'b001, 3'b000, 5'h05, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 0, 3'b001, 3'b001, 8'h3C, 0);

    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    // All three ports requesting continuously without lock rotate 0,1,2.
    fairGnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    doReset();
    req0 = 1; req1 = 1; req2 = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("fair%0d gnt", k), {5'b0, gnt2, gnt1, gnt0}, {5'b0, fairGnt[k]});
      @(negedge clk);
    end

    // Host lock with ports 0/1 pending: 0,1 served first, then 8 host grants, then 0,1 again.
    lockGnt = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    lockExp = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    doReset();
    req0 = 1; req1 = 1; req2 = 1; host_lock = 1;
    for (int k = 0; k < 13; k++) begin
      #1;
      checkOutput($sformatf("lock%0d gnt", k), {5'b0, gnt2, gnt1, gnt0}, {5'b0, lockGnt[k]});
      @(posedge clk);
      #1;
      checkOutput($sformatf("lock%0d locked", k), {7'b0, locked}, {7'b0, lockExp[k]});
      @(negedge clk);
    end

    // Host write burst interrupted by reset between the 2nd and 3rd write.
    doReset();
    for (int k = 0; k < 2; k++) begin
      req2 = 1; we2 = 1; host_lock = 1; addr2 = 5'(k); wdata2 = 8'h11 + 8'(k);
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("burst locked before reset", {7'b0, locked}, 8'h01);
    addr2 = 5'd2; wdata2 = 8'h13;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("burst locked async clear", {7'b0, locked}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      req2 = 1; we2 = 0; addr2 = 5'(a);
      @(posedge clk);
      #1;
      checkOutput($sformatf("burst readback%0d rdata", a), rdata, 8'h00);
      checkOutput($sformatf("burst readback%0d rvalid2", a), {7'b0, rvalid2}, 8'h01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/shared_mem_arb.md
# shared_mem_arb

Single-port arbiter and owner of the 32×8 unified memory, shared by three requesters: core instruction fetch (port 0), core LD/ST data access (port 1), and a host loader/debug port (port 2). It performs at most one memory access per cycle. Requesters are served round-robin, and the host can take a bounded burst lock for program loading. It sits between the 8-bit core and the memory array, replacing the core's direct memory indexing.

## Interface
Parameters:
- DW, 8, data width
- AW, 5, address width (DEPTH = 2**AW = 32 bytes)
- LOCK_MAX, 8, maximum consecutive host grants under lock (range 1–255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1 / req2  in  1 each  access request, ports 0/1/2
- we0 / we1 / we2  in  1 each  1 = write, 0 = read
- addr0 / addr1 / addr2  in  AW each  byte address
- wdata0 / wdata1 / wdata2  in  DW each  write data
- host_lock  in  1  host burst-lock request, qualifies req2
- gnt0 / gnt1 / gnt2  out  1 each  combinational grant, one-hot or zero
- rvalid0 / rvalid1 / rvalid2  out  1 each  read data valid for that port, registered
- rdata  out  DW  registered read data, shared by all ports
- locked  out  1  host lock currently active, registered

## Operation
- One clock and one reset domain. Reset asynchronously clears the following:
  - all 32 memory bytes to 0x00
  - rdata = 0x00; rvalid0..2 = 0; locked = 0; lock counter = 0
  - round-robin pointer last = 2, so the first priority order is 0, 1, 2
- Arbitration is combinational on the current cycle's requests:
  - If locked = 1 and req2 = 1: gnt2 = 1.
  - Otherwise, grant the first requesting port in order last+1, last+2, last+3 (mod 3).
  - With no requests, all grants are 0.
- The granted access commits on the next rising edge:
  - Write: mem[addr] <= wdata.
  - Read: rdata <= mem[addr] and rvalid for the granted port <= 1.
  - rvalid for all other ports <= 0.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high.
  - The transfer completes in the cycle gnt is high.
  - The requester may drop req or present a new request the next cycle.
  - An ungranted request has no side effect.
- Pointer: on any grant, last <= granted port index. With no grant, last holds.
- Lock state machine (states UNLOCKED and LOCKED; counter is 8 bits):
  - UNLOCKED → LOCKED: gnt2 = 1 and host_lock = 1 at the edge. Set cnt = 1.
  - While LOCKED, each host grant increments cnt.
  - LOCKED → UNLOCKED on any of:
    - req2 = 0
    - host_lock = 0
    - cnt = LOCK_MAX at a host grant
  - After a forced release at LOCK_MAX, the host can relock only after a round-robin grant to it. That grant occurs after any pending port 0/1 request is served, because last = 2.
- There is no address range check; every AW-bit address is valid.
- rdata holds its last value when no read occurs; only rvalid pulses.

## Timing
- Grant latency: 0 cycles (combinational from req).
- Write visibility: a write granted in cycle N is readable by a read granted in cycle N+1.
- Read latency: 1 cycle. rdata and rvalidX are valid in cycle N+1 for a read granted in cycle N.
- Back-to-back grants to different ports each get one cycle. Sustained throughput is 1 access/cycle.
- Fairness: with all three ports requesting continuously and no lock, each port is granted exactly once every 3 cycles.
- Worst-case wait for port 0 or 1 is LOCK_MAX + 2 cycles.
- Reset asserted mid-burst behaves as follows:
  - locked, rvalid and pointer return to their reset values immediately (asynchronously).
  - Memory clears, and no write is committed on that edge.
- On deassertion, the first arbitration uses order 0, 1, 2.

## Test plan
- Reset, then read all 32 addresses via port 2 → rdata = 0x00 and rvalid2 = 1 one cycle after each grant; locked = 0.
- Port 2 writes 0xA5 to address 0x13, then port 0 reads 0x13 the next cycle → gnt0 is high, and rdata = 0xA5 with rvalid0 = 1 one cycle later.
- req0, req1 and req2 held continuously from reset release with no lock → grant sequence 0, 1, 2, 0, 1, 2; no port is granted twice in any 3-cycle window.
- host_lock = 1 and req2 held with LOCK_MAX = 8 while req0 and req1 are pending:
  - locked rises after the first host grant.
  - Exactly 8 consecutive host grants occur.
  - Then gnt0 and gnt1 each get one cycle before the host is granted again.
- Host burst of writes 0x11–0x14 to addresses 0–3; reset asserted between the 2nd and 3rd write; then readback → all four bytes read 0x00, and locked drops asynchronously.
- Port 1 reads address 5 (holding 0x3C) while port 0 is idle → rvalid1 pulses for exactly one cycle; rdata stays 0x3C afterwards with rvalid1 = 0.
